// File: rtl/vram_pkg.sv
// Shared types and widths for the video RAM arbiter: bus widths, read FSM
// encoding and the posted-write FIFO entry layout.
package vram_pkg;

    localparam int VRAM_AW    = 14;
    localparam int VRAM_DW    = 16;
    localparam int VRAM_BW    = 2;
    localparam int WR_ENTRY_W = VRAM_AW + VRAM_BW + VRAM_DW;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_RD_ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_BW-1:0] bytesel;
        logic [VRAM_DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vram_wrfifo.sv
// Posted CPU write buffer: synchronous FIFO, pointers one bit wider than the
// index so full and empty are distinguished without a counter.
module vram_wrfifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WR_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head     = wr_entry_t'(mem_q[rd_ptr_q[AW-1:0]]);
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the line fetcher always wins, CPU writes are posted
// and drained in free cycles, CPU reads wait for an empty write buffer.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int WRFIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gfx_active,
    input  logic [VRAM_AW-1:0] gfx_addr,
    output logic [VRAM_DW-1:0] gfx_data,
    input  logic               cpu_req,
    input  logic               cpu_wren,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_BW-1:0] cpu_bytesel,
    input  logic [VRAM_DW-1:0] cpu_wrdata,
    output logic               cpu_ack,
    output logic [VRAM_DW-1:0] cpu_rddata,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic [VRAM_DW-1:0] ram_wrdata,
    output logic [VRAM_BW-1:0] ram_bytesel,
    output logic               ram_wren,
    input  logic [VRAM_DW-1:0] ram_rddata
);

    state_t             state_q, state_d;
    logic               rd_ack_q, rd_ack_d;
    logic [VRAM_DW-1:0] cpu_rddata_q, cpu_rddata_d;

    logic      fifo_push, fifo_pop, fifo_full, fifo_empty, rd_issue;
    wr_entry_t push_entry, head_entry;

    vram_wrfifo #(
        .DEPTH(WRFIFO_DEPTH)
    ) u_wrfifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .head     (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The ack cycle of a read still sees the same read held on the bus, so a
    // new read may only be issued once rd_ack_q has dropped.
    always_comb begin
        push_entry.addr    = cpu_addr;
        push_entry.bytesel = cpu_bytesel;
        push_entry.data    = cpu_wrdata;
        fifo_push = reset && cpu_req && cpu_wren && !fifo_full;
        fifo_pop  = reset && !gfx_active && !fifo_empty && (state_q == ST_IDLE);
        rd_issue  = reset && cpu_req && !cpu_wren && fifo_empty && !gfx_active &&
                    (state_q == ST_IDLE) && !rd_ack_q;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value held and no latch is inferred.
    always_comb begin
        ram_addr    = '0;
        ram_wrdata  = '0;
        ram_bytesel = '0;
        ram_wren    = 1'b0;
        if (gfx_active) begin
            ram_addr = gfx_addr;
        end else if (fifo_pop) begin
            ram_addr    = head_entry.addr;
            ram_wrdata  = head_entry.data;
            ram_bytesel = head_entry.bytesel;
            ram_wren    = 1'b1;
        end else if (rd_issue) begin
            ram_addr = cpu_addr;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_ack_d     = 1'b0;
        cpu_rddata_d = cpu_rddata_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_issue) state_d = ST_RD_ISSUE;
            end
            ST_RD_ISSUE: begin
                state_d      = ST_IDLE;
                rd_ack_d     = 1'b1;
                cpu_rddata_d = ram_rddata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rd_ack_q     <= 1'b0;
            cpu_rddata_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ack_q     <= rd_ack_d;
            cpu_rddata_q <= cpu_rddata_d;
        end
    end

    assign gfx_data   = ram_rddata;
    assign cpu_ack    = fifo_push || (reset && rd_ack_q);
    assign cpu_rddata = cpu_rddata_q;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 16-bit video RAM between the graphics line fetcher and the CPU bus.
- The fetcher has absolute priority and zero added latency: it drives an address and reads data the next cycle, and it never stalls.
- CPU writes are posted into a small FIFO and drained in free cycles.
- CPU reads wait until the FIFO is empty and a free cycle exists, so CPU accesses stay in order.

Parameters:
- WRFIFO_DEPTH, 4, number of posted CPU writes buffered; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- gfx_active  in  1  fetcher owns the RAM this cycle
- gfx_addr  in  14  fetcher word address, used combinationally
- gfx_data  out  16  RAM read data returned to the fetcher
- cpu_req  in  1  CPU access request
- cpu_wren  in  1  1 = write, 0 = read
- cpu_addr  in  14  CPU word address
- cpu_bytesel  in  2  write byte enables; [1] = bits 15:8
- cpu_wrdata  in  16  CPU write data
- cpu_ack  out  1  one-cycle completion/acceptance pulse
- cpu_rddata  out  16  CPU read data, valid when cpu_ack is high on a read
- ram_addr  out  14  RAM address
- ram_wrdata  out  16  RAM write data
- ram_bytesel  out  2  RAM byte write enables
- ram_wren  out  1  RAM write strobe
- ram_rddata  in  16  RAM read data, registered, available 1 cycle after the address

Behaviour:
- Reset (reset == 0 at a clk edge):
  - FIFO emptied; state = ST_IDLE.
  - cpu_ack = 0, cpu_rddata = 0, ram_wren = 0, ram_bytesel = 0.
  - ram_addr/ram_wrdata are 0 when gfx_active = 0.
- gfx_data = ram_rddata (pure pass-through).
- Fetcher port:
  - gfx_active = 1 → ram_addr = gfx_addr and ram_wren = 0, combinationally, in the same cycle.
  - CPU activity that cycle is deferred; nothing is lost.
- CPU write acceptance:
  - cpu_req & cpu_wren & FIFO not full → push {addr, bytesel, data}; cpu_ack = 1 in the same cycle (combinational).
  - FIFO full → no ack; the request is held until space frees.
  - A push and a drain in the same cycle are both allowed; occupancy stays unchanged.
- Write drain:
  - Condition: !gfx_active & FIFO not empty & state ST_IDLE.
  - Action: pop the head; drive ram_addr/ram_wrdata/ram_bytesel with ram_wren = 1 for one cycle.
  - The drain rate is 1 write per free cycle.
- CPU read state machine:
  - ST_IDLE → ST_RD_ISSUE when cpu_req & !cpu_wren & FIFO empty & !gfx_active. The read address is issued in that same cycle: ram_addr = cpu_addr, ram_wren = 0.
  - ST_RD_ISSUE → ST_IDLE unconditionally:
    - cpu_rddata ← ram_rddata (registered);
    - cpu_ack pulses 1 in the cycle cpu_rddata becomes valid.
    - Read latency is 2 cycles from issue to ack.
  - gfx_active = 1 during ST_RD_ISSUE is legal: the read was already issued and the RAM pipeline returns the correct data.
  - No write drain occurs in ST_RD_ISSUE.
- Handshake:
  - The CPU holds req/fields stable until ack.
  - The CPU may keep req high after ack to present a new transaction; the arbiter treats the cycle after ack as a new request.
  - A read is never acked while a write is still queued (ordering / read-after-write).
- Starvation: the CPU may wait indefinitely while gfx_active = 1. This is by design; the fetcher is idle during horizontal blanking.
- Reset mid-operation:
  - Queued writes are discarded.
  - A pending read is abandoned with no ack.

Decomposition:
- Package vram_pkg: VRAM_AW = 14, VRAM_DW = 16, state encoding (ST_IDLE, ST_RD_ISSUE), FIFO entry width (14 + 2 + 16 = 32).
- Sub-module vram_wrfifo: synchronous FIFO with push/pop/full/empty, pointers one bit wider than log2(depth), same clk/reset.

Test Plan:
- Reset, then CPU write addr=0x0123 data=0xBEEF bytesel=11 with gfx_active = 0 → ack the same cycle; next cycle ram_wren = 1, ram_addr = 0x0123, ram_wrdata = 0xBEEF.
- gfx_active = 1 held for 10 cycles while the CPU posts 5 writes → acks 1–4 immediately, the 5th waits; ram_addr tracks gfx_addr each cycle with ram_wren never 1; on gfx_active → 0, writes drain in order on consecutive cycles and the 5th is acked once space frees.
- Write 0x1234 to addr 0x0010, then immediately read 0x0010 → read ack only after the drain; cpu_rddata = 0x1234 two cycles after the read issue.
- Byte write bytesel=10 data=0xAA55 to a word holding 0x0000 → ram_bytesel = 10; a subsequent read returns 0xAA00 (RAM model).
- Read issued, with gfx_active rising in the next cycle → cpu_ack and correct cpu_rddata still arrive; gfx_data matches RAM contents at gfx_addr with 1-cycle latency.
- Reset asserted with 3 writes queued and a read pending → no ram_wren and no cpu_ack afterwards; FIFO empty; cpu_rddata = 0.
